// File: rtl/wb_io_decoder.sv
// Wishbone address decoder and bridge: ROM, RAM, N peripheral channels, GPIO.
// Single transaction in flight; registered outputs throughout.
module wb_io_decoder #(
    parameter int              DW         = 8,
    parameter int              AW         = 16,
    parameter int              ROM_AW     = 14,
    parameter int              RAM_AW     = 15,
    parameter logic [AW-1:0]   ROM_LIMIT  = 16'h4000,
    parameter logic [AW-1:0]   RAM_LIMIT  = 16'hA000,
    parameter int              NUM_PERIPH = 2,
    parameter int              MEM_WAIT   = 1,
    parameter int              TIMEOUT    = 255,
    parameter int              TO_W       = 8,
    parameter int              GPIO_W     = 8,
    parameter logic [GPIO_W-1:0] GPIO_RESET = '0
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [AW-1:0]            i_wb_addr,
    input  logic [DW-1:0]            i_wb_data,
    output logic                     o_wb_ack,
    output logic                     o_wb_stall,
    output logic [DW-1:0]            o_wb_data,
    output logic [ROM_AW-1:0]        o_rom_addr,
    output logic                     o_rom_stb,
    input  logic [DW-1:0]            i_rom_data,
    output logic [RAM_AW-1:0]        o_ram_addr,
    output logic                     o_ram_stb,
    output logic                     o_ram_wr,
    output logic [DW-1:0]            o_ram_data,
    input  logic [DW-1:0]            i_ram_data,
    output logic [NUM_PERIPH-1:0]    o_periph_cyc,
    output logic [NUM_PERIPH-1:0]    o_periph_stb,
    output logic                     o_periph_we,
    output logic [DW-1:0]            o_periph_data,
    input  logic [NUM_PERIPH*DW-1:0] i_periph_data,
    input  logic [NUM_PERIPH-1:0]    i_periph_ack,
    input  logic [NUM_PERIPH-1:0]    i_periph_stall,
    input  logic [NUM_PERIPH*DW-1:0] i_periph_status,
    output logic [GPIO_W-1:0]        o_gpio,
    output logic [7:0]               o_err_count
);

    localparam int CH_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
    localparam logic [AW-1:0] GPIO_OFF = AW'(2 * NUM_PERIPH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT);
    localparam logic [2:0] MW_LAST = 3'(MEM_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_PREQ,
        S_PWAIT,
        S_RESP
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     sel;
    logic [TO_W-1:0]     to_cnt;
    logic [2:0]          mem_cnt;
    logic                mem_rom;
    logic                mem_wr;

    logic [AW-1:0]         io_off;
    logic [CH_W-1:0]       ch;
    logic [NUM_PERIPH-1:0] ch_onehot;
    logic                  is_rom;
    logic                  is_ram;
    logic                  in_io;
    logic                  is_stat;
    logic                  is_pdat;
    logic                  is_gpio;
    logic [DW-1:0]         stat_data;
    logic [DW-1:0]         gpio_rd;
    logic [RAM_AW-1:0]     ram_addr;
    logic [7:0]            err_next;

    always_comb begin
        io_off    = i_wb_addr - RAM_LIMIT;
        ch        = CH_W'(io_off >> 1);
        ch_onehot = NUM_PERIPH'(1) << ch;
        is_rom    = i_wb_addr < ROM_LIMIT;
        is_ram    = !is_rom && (i_wb_addr < RAM_LIMIT);
        in_io     = !is_rom && !is_ram;
        is_stat   = in_io && (io_off < GPIO_OFF) && !io_off[0];
        is_pdat   = in_io && (io_off < GPIO_OFF) && io_off[0];
        is_gpio   = in_io && (io_off == GPIO_OFF);
        stat_data = i_periph_status[int'(ch)*DW +: DW];
        // Modular subtraction: low bits of the difference need only low bits
        ram_addr  = RAM_AW'(i_wb_addr) - RAM_AW'(ROM_LIMIT);
        gpio_rd   = '0;
        gpio_rd[GPIO_W-1:0] = o_gpio;
        err_next  = (o_err_count == 8'hFF) ? o_err_count : o_err_count + 8'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= S_IDLE;
            sel           <= '0;
            to_cnt        <= '0;
            mem_cnt       <= '0;
            mem_rom       <= 1'b0;
            mem_wr        <= 1'b0;
            o_wb_ack      <= 1'b0;
            o_wb_stall    <= 1'b0;
            o_wb_data     <= '0;
            o_rom_addr    <= '0;
            o_rom_stb     <= 1'b0;
            o_ram_addr    <= '0;
            o_ram_stb     <= 1'b0;
            o_ram_wr      <= 1'b0;
            o_ram_data    <= '0;
            o_periph_cyc  <= '0;
            o_periph_stb  <= '0;
            o_periph_we   <= 1'b0;
            o_periph_data <= '0;
            o_gpio        <= GPIO_RESET;
            o_err_count   <= '0;
        end else begin
            o_wb_ack  <= 1'b0;
            o_rom_stb <= 1'b0;
            o_ram_stb <= 1'b0;
            o_ram_wr  <= 1'b0;
            if (state != S_IDLE && !i_wb_cyc) begin
                // Master abandoned the cycle: drop everything, no ack
                state        <= S_IDLE;
                o_wb_stall   <= 1'b0;
                o_periph_cyc <= '0;
                o_periph_stb <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (i_wb_cyc && i_wb_stb) begin
                            o_wb_stall <= 1'b1;
                            sel        <= ch;
                            to_cnt     <= '0;
                            mem_cnt    <= '0;
                            mem_rom    <= is_rom;
                            mem_wr     <= is_ram && i_wb_we;
                            o_wb_data  <= '0;
                            unique case (1'b1)
                                is_rom: begin
                                    if (i_wb_we) begin
                                        o_wb_ack <= 1'b1;
                                        state    <= S_RESP;
                                    end else begin
                                        o_rom_addr <= i_wb_addr[ROM_AW-1:0];
                                        o_rom_stb  <= 1'b1;
                                        state      <= S_MEM;
                                    end
                                end
                                is_ram: begin
                                    o_ram_addr <= ram_addr;
                                    o_ram_stb  <= 1'b1;
                                    o_ram_wr   <= i_wb_we;
                                    o_ram_data <= i_wb_data;
                                    state      <= S_MEM;
                                end
                                is_stat: begin
                                    o_wb_data <= i_wb_we ? '0 : stat_data;
                                    o_wb_ack  <= 1'b1;
                                    state     <= S_RESP;
                                end
                                is_pdat: begin
                                    o_periph_cyc  <= ch_onehot;
                                    o_periph_stb  <= ch_onehot;
                                    o_periph_we   <= i_wb_we;
                                    o_periph_data <= i_wb_data;
                                    state         <= S_PREQ;
                                end
                                is_gpio: begin
                                    if (i_wb_we)
                                        o_gpio <= i_wb_data[GPIO_W-1:0];
                                    o_wb_data <= i_wb_we ? '0 : gpio_rd;
                                    o_wb_ack  <= 1'b1;
                                    state     <= S_RESP;
                                end
                                default: begin
                                    o_wb_data   <= '1;
                                    o_wb_ack    <= 1'b1;
                                    o_err_count <= err_next;
                                    state       <= S_RESP;
                                end
                            endcase
                        end
                    end
                    S_MEM: begin
                        if (mem_wr) begin
                            o_wb_ack <= 1'b1;
                            state    <= S_RESP;
                        end else if (mem_cnt == MW_LAST) begin
                            o_wb_data <= mem_rom ? i_rom_data : i_ram_data;
                            o_wb_ack  <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            mem_cnt <= mem_cnt + 3'd1;
                        end
                    end
                    S_PREQ, S_PWAIT: begin
                        if (i_periph_ack[sel]) begin
                            o_wb_data    <= i_periph_data[int'(sel)*DW +: DW];
                            o_periph_cyc <= '0;
                            o_periph_stb <= '0;
                            o_wb_ack     <= 1'b1;
                            state        <= S_RESP;
                        end else if (to_cnt == TO_LAST) begin
                            o_wb_data    <= '1;
                            o_periph_cyc <= '0;
                            o_periph_stb <= '0;
                            o_err_count  <= err_next;
                            o_wb_ack     <= 1'b1;
                            state        <= S_RESP;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                            if (state == S_PREQ && !i_periph_stall[sel]) begin
                                o_periph_stb <= '0;
                                state        <= S_PWAIT;
                            end
                        end
                    end
                    S_RESP: begin
                        o_wb_stall <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: begin
                        o_wb_stall <= 1'b0;
                        state      <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
